// File: rtl/ddr_phase_cal.sv
// DDR read-clock phase calibration: sweeps psda over 16 phases, records a pass map,
// then centres psda in the longest circular passing window. Optional macro: DDR_PHASE_CAL_RELOCK_EN.
module ddr_phase_cal #(
    parameter int unsigned SETTLE_CYCLES = 64,
    parameter logic [3:0]  FDLY_VAL      = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic       start,
    input  logic       test_done,
    input  logic       test_pass,
    output logic       test_req,
    output logic [3:0] psda,
    output logic [3:0] fdly,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [3:0] win_start,
    output logic [4:0] win_len
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LOCK,
        S_SETTLE,
        S_TEST,
        S_EVAL,
        S_DONE,
        S_FAIL
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       psda_q, psda_d;
    logic             test_req_q, test_req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic [3:0]       win_start_q, win_start_d;
    logic [4:0]       win_len_q, win_len_d;
    logic [15:0]      pass_map_q, pass_map_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [4:0]       eval_idx_q, eval_idx_d;
    logic [4:0]       cur_len_q, cur_len_d;
    logic [3:0]       cur_start_q, cur_start_d;
    logic [4:0]       best_len_q, best_len_d;
    logic [3:0]       best_start_q, best_start_d;

    logic       scan_bit;
    logic [4:0] run_len;
    logic [3:0] run_start;
    logic [4:0] step_best_len;
    logic [3:0] step_best_start;

    // One step of the circular run search: the map is scanned twice (32 steps) so wrapped
    // runs are seen whole; strict '>' keeps the earliest start on ties.
    always_comb begin
        scan_bit        = pass_map_q[eval_idx_q[3:0]];
        run_len         = 5'd0;
        run_start       = cur_start_q;
        step_best_len   = best_len_q;
        step_best_start = best_start_q;
        if (scan_bit) begin
            run_start = (cur_len_q == 5'd0) ? eval_idx_q[3:0] : cur_start_q;
            run_len   = (cur_len_q == 5'd16) ? 5'd16 : cur_len_q + 5'd1;
        end
        if (run_len > best_len_q) begin
            step_best_len   = run_len;
            step_best_start = run_start;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            psda_q       <= 4'd0;
            test_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            win_start_q  <= 4'd0;
            win_len_q    <= 5'd0;
            pass_map_q   <= 16'd0;
            settle_cnt_q <= '0;
            eval_idx_q   <= 5'd0;
            cur_len_q    <= 5'd0;
            cur_start_q  <= 4'd0;
            best_len_q   <= 5'd0;
            best_start_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            psda_q       <= psda_d;
            test_req_q   <= test_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            win_start_q  <= win_start_d;
            win_len_q    <= win_len_d;
            pass_map_q   <= pass_map_d;
            settle_cnt_q <= settle_cnt_d;
            eval_idx_q   <= eval_idx_d;
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        psda_d       = psda_q;
        test_req_d   = test_req_q;
        busy_d       = busy_q;
        done_d       = done_q;
        fail_d       = fail_q;
        win_start_d  = win_start_q;
        win_len_d    = win_len_q;
        pass_map_d   = pass_map_q;
        settle_cnt_d = settle_cnt_q;
        eval_idx_d   = eval_idx_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;

        // Losing PLL lock mid-calibration overrides every other transition.
        if (!locked && (state_q inside {S_SETTLE, S_TEST, S_EVAL})) begin
            test_req_d   = 1'b0;
            psda_d       = 4'd0;
            settle_cnt_d = '0;
`ifdef DDR_PHASE_CAL_RELOCK_EN
            pass_map_d   = 16'd0;
            state_d      = S_WAIT_LOCK;
`else
            fail_d       = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_FAIL;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        done_d      = 1'b0;
                        fail_d      = 1'b0;
                        win_start_d = 4'd0;
                        win_len_d   = 5'd0;
                        pass_map_d  = 16'd0;
                        psda_d      = 4'd0;
                        busy_d      = 1'b1;
                        state_d     = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked) begin
                        settle_cnt_d = '0;
                        state_d      = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        settle_cnt_d = '0;
                        test_req_d   = 1'b1;
                        state_d      = S_TEST;
                    end else begin
                        settle_cnt_d = settle_cnt_q + CNT_W'(1);
                    end
                end
                S_TEST: begin
                    if (test_req_q && test_done) begin
                        pass_map_d[psda_q] = test_pass;
                        test_req_d         = 1'b0;
                        if (psda_q == 4'd15) begin
                            eval_idx_d   = 5'd0;
                            cur_len_d    = 5'd0;
                            cur_start_d  = 4'd0;
                            best_len_d   = 5'd0;
                            best_start_d = 4'd0;
                            state_d      = S_EVAL;
                        end else begin
                            psda_d  = psda_q + 4'd1;
                            state_d = S_SETTLE;
                        end
                    end
                end
                S_EVAL: begin
                    cur_len_d    = run_len;
                    cur_start_d  = run_start;
                    best_len_d   = step_best_len;
                    best_start_d = step_best_start;
                    eval_idx_d   = eval_idx_q + 5'd1;
                    if (eval_idx_q == 5'd31) begin
                        win_start_d = step_best_start;
                        win_len_d   = step_best_len;
                        busy_d      = 1'b0;
                        if (step_best_len != 5'd0) begin
                            psda_d  = step_best_start + step_best_len[4:1];
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            psda_d  = 4'd0;
                            fail_d  = 1'b1;
                            state_d = S_FAIL;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign test_req  = test_req_q;
    assign psda      = psda_q;
    assign fdly      = FDLY_VAL;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fail      = fail_q;
    assign win_start = win_start_q;
    assign win_len   = win_len_q;

endmodule

// File: tb/tb_ddr_phase_cal.sv
// Directed bench for ddr_phase_cal: a read-test responder answers from a per-case pass map.
module tb_ddr_phase_cal;

    logic       clk;
    logic       rst;
    logic       locked;
    logic       start;
    logic       test_done;
    logic       test_pass;
    logic       test_req;
    logic [3:0] psda;
    logic [3:0] fdly;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] win_start;
    logic [4:0] win_len;

    int n_checks = 0;
    int n_pass   = 0;
    int n_resp   = 0;
    int viol     = 0;

    logic [15:0] map_tb     = 16'h0000;
    logic [4:0]  hold_phase = 5'd16;

    ddr_phase_cal #(
        .SETTLE_CYCLES(4),
        .FDLY_VAL     (4'b1111)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .start    (start),
        .test_done(test_done),
        .test_pass(test_pass),
        .test_req (test_req),
        .psda     (psda),
        .fdly     (fdly),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .win_start(win_start),
        .win_len  (win_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: answers a request two cycles after it appears, unless held at hold_phase.
    initial begin
        int resp_cnt;
        resp_cnt  = 0;
        test_done = 1'b0;
        test_pass = 1'b0;
        forever begin
            @(negedge clk);
            if (test_done) begin
                test_done = 1'b0;
                test_pass = 1'b0;
            end else if (test_req && ({1'b0, psda} != hold_phase)) begin
                if (resp_cnt == 1) begin
                    test_done = 1'b1;
                    test_pass = map_tb[psda];
                    resp_cnt  = 0;
                    n_resp++;
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // psda must never move while test_req stays high.
    initial begin
        logic       prev_req;
        logic [3:0] prev_psda;
        prev_req  = 1'b0;
        prev_psda = 4'd0;
        forever begin
            @(negedge clk);
            if (!rst && test_req && prev_req && (psda != prev_psda)) viol++;
            prev_req  = test_req;
            prev_psda = psda;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        k = 0;
        while (!(done || fail) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_req_at(input logic [3:0] ph, input string tag);
        int k;
        k = 0;
        while (!(test_req && psda == ph) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 3000) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_case(input string tag, input logic [15:0] map, input logic exp_done,
                            input logic [3:0] exp_ws, input logic [4:0] exp_wl,
                            input logic [3:0] exp_psda);
        map_tb = map;
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_end(tag);
        cycles(1);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_fail"}, 32'(fail), 32'(!exp_done));
        check({tag, "_ws"}, 32'(win_start), 32'(exp_ws));
        check({tag, "_wl"}, 32'(win_len), 32'(exp_wl));
        check({tag, "_psda"}, 32'(psda), 32'(exp_psda));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        rst    = 1'b1;
        locked = 1'b1;
        start  = 1'b0;
        cycles(3);
        check("rst_psda", 32'(psda), 32'd0);
        check("rst_fdly", 32'(fdly), 32'hF);
        check("rst_flags", {28'd0, test_req, busy, done, fail}, 32'd0);
        check("rst_win", {23'd0, win_start, win_len}, 32'd0);
        rst = 1'b0;
        cycles(5);
        check("idle_hold", {28'd0, test_req, busy, done, fail}, 32'd0);

        run_case("win4_8", 16'h0FF0, 1'b1, 4'd4, 5'd8, 4'd8);
        run_case("wrap", 16'hC007, 1'b1, 4'd14, 5'd5, 4'd0);
        run_case("allpass", 16'hFFFF, 1'b1, 4'd0, 5'd16, 4'd8);
        run_case("nopass", 16'h0000, 1'b0, 4'd0, 5'd0, 4'd0);
        run_case("tie", 16'h0E0E, 1'b1, 4'd1, 5'd3, 4'd2);

        // Lock lost while phase 6 is under test.
        map_tb     = 16'h0FF0;
        hold_phase = 5'd6;
        pulse_start();
        wait_req_at(4'd6, "lock_req6");
        locked = 1'b0;
        cycles(2);
        check("lock_req", 32'(test_req), 32'd0);
        check("lock_psda", 32'(psda), 32'd0);
`ifdef DDR_PHASE_CAL_RELOCK_EN
        check("relock_busy", 32'(busy), 32'd1);
        check("relock_flags", {30'd0, done, fail}, 32'd0);
        hold_phase = 5'd16;
        base       = n_resp;
        locked     = 1'b1;
        wait_end("relock");
        cycles(1);
        check("relock_done", {30'd0, done, fail}, 32'd2);
        check("relock_psda", 32'(psda), 32'd8);
        check("relock_tests", 32'(n_resp - base), 32'd16);
`else
        check("lock_fail", {29'd0, busy, done, fail}, 32'd1);
        hold_phase = 5'd16;
        locked     = 1'b1;
        cycles(3);
        check("lock_fail_hold", {29'd0, busy, done, fail}, 32'd1);
`endif

        // Reset pulsed in the middle of phase 9's test.
        hold_phase = 5'd9;
        pulse_start();
        wait_req_at(4'd9, "rst_req9");
        #2 rst = 1'b1;
        #1;
        check("midrst_flags", {28'd0, test_req, busy, done, fail}, 32'd0);
        check("midrst_psda", 32'(psda), 32'd0);
        check("midrst_win", {23'd0, win_start, win_len}, 32'd0);
        hold_phase = 5'd16;
        cycles(2);
        rst = 1'b0;
        cycles(3);
        check("midrst_idle", 32'(busy), 32'd0);
        base = n_resp;
        run_case("postrst", 16'h0FF0, 1'b1, 4'd4, 5'd8, 4'd8);
        check("postrst_tests", 32'(n_resp - base), 32'd16);

        check("psda_stable", 32'(viol), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
